// File: rtl/lvds_rx.sv
// lvds_rx: deserializes the 2-bit DDR pair stream into 32-bit I/Q words aligned on in-band markers.
// Optional overflow counter is built only when LVDS_RX_DROP_CNT_EN is defined.
`timescale 1ns/1ps
module lvds_rx #(
   parameter int DROP_CNT_W = 16
) (
   input  logic                  i_ddr_clk,
   input  logic                  i_rst_b,
   input  logic [1:0]            i_ddr_data,
   input  logic                  i_fifo_full,
   output logic                  o_fifo_write_clk,
   output logic                  o_fifo_push,
   output logic [31:0]           o_fifo_data,
   output logic                  o_sync_err,
   output logic [DROP_CNT_W-1:0] o_drop_count,
   output logic [1:0]            o_debug_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      I_PHASE = 2'b01,
      Q_PHASE = 2'b10,
      UNUSED  = 2'b11
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] word_q, word_d;
   logic [31:0] data_q, data_d;
   logic        push_q, push_d;
   logic        err_q, err_d;
   logic        done;
   logic [31:0] shifted;

   assign shifted = {word_q[29:0], i_ddr_data};

   // Marker hunt: IDLE consumes the I marker itself, so a new word can follow with no gap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      err_d   = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_ddr_data == 2'b10) begin
               word_d  = shifted;
               cnt_d   = 3'd1;
               state_d = I_PHASE;
            end
         end
         I_PHASE: begin
            word_d = shifted;
            if (cnt_q == 3'd7) begin
               cnt_d   = 3'd0;
               state_d = Q_PHASE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         Q_PHASE: begin
            if (cnt_q == 3'd0 && i_ddr_data != 2'b01) begin
               err_d   = 1'b1;
               cnt_d   = 3'd0;
               state_d = IDLE;
            end else begin
               word_d = shifted;
               if (cnt_q == 3'd7) begin
                  done    = 1'b1;
                  cnt_d   = 3'd0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         default: begin
            cnt_d   = 3'd0;
            state_d = IDLE;
         end
      endcase
   end

   assign push_d = done & ~i_fifo_full;
   assign data_d = push_d ? word_d : data_q;

   always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         word_q  <= 32'd0;
         data_q  <= 32'd0;
         push_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         data_q  <= data_d;
         push_q  <= push_d;
         err_q   <= err_d;
      end
   end

`ifdef LVDS_RX_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_q, drop_d;

   // Saturating count of completed words lost to a full FIFO.
   always_comb begin
      drop_d = drop_q;
      if (done && i_fifo_full && drop_q != {DROP_CNT_W{1'b1}}) begin
         drop_d = drop_q + DROP_CNT_W'(1);
      end
   end

   always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign o_drop_count = drop_q;
`else
   assign o_drop_count = '0;
`endif

   assign o_fifo_write_clk = i_ddr_clk;
   assign o_fifo_push      = push_q;
   assign o_fifo_data      = data_q;
   assign o_sync_err       = err_q;
   assign o_debug_state    = state_q;

endmodule

// File: tb/tb_lvds_rx.sv
// tb_lvds_rx: directed and randomized pair streams checked against a word-parsing reference model.
`timescale 1ns/1ps
module tb_lvds_rx;

   localparam int DropCntW = 16;
   localparam int unsigned MaxDrop = (1 << DropCntW) - 1;
`ifdef LVDS_RX_DROP_CNT_EN
   localparam bit DropEn = 1'b1;
`else
   localparam bit DropEn = 1'b0;
`endif

   logic                clock;
   logic                rstB;
   logic [1:0]          ddrData;
   logic                fifoFull;
   logic                writeClk;
   logic                fifoPush;
   logic [31:0]         fifoData;
   logic                syncErr;
   logic [DropCntW-1:0] dropCount;
   logic [1:0]          debugState;

   int errors = 0;
   int checks = 0;

   logic [1:0]  stimPairs[$];
   bit          stimFull[$];
   bit          expPush [0:1023];
   bit          expErr  [0:1023];
   bit          expDrop [0:1023];
   logic [31:0] expWord [0:1023];
   logic [31:0] mLastData;
   int unsigned mDrop;

   lvds_rx #(.DROP_CNT_W(DropCntW)) dut (
      .i_ddr_clk        (clock),
      .i_rst_b          (rstB),
      .i_ddr_data       (ddrData),
      .i_fifo_full      (fifoFull),
      .o_fifo_write_clk (writeClk),
      .o_fifo_push      (fifoPush),
      .o_fifo_data      (fifoData),
      .o_sync_err       (syncErr),
      .o_drop_count     (dropCount),
      .o_debug_state    (debugState)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one pair, let the next rising edge take it, then settle 1ns past the edge.
   task automatic applyStimulus(input logic [1:0] pair, input bit full);
      ddrData  = pair;
      fifoFull = full;
      @(posedge clock);
      #1;
   endtask

   task automatic pushWord(input logic [31:0] w, input bit full);
      for (int k = 0; k < 16; k++) begin
         stimPairs.push_back(2'((w >> (30 - 2 * k)) & 32'd3));
         stimFull.push_back(full);
      end
   endtask

   task automatic padIdle(input int n);
      for (int k = 0; k < n; k++) begin
         stimPairs.push_back(2'b00);
         stimFull.push_back(1'b0);
      end
   endtask

   // Reference: scan the pair list for an I marker, demand a Q marker 8 pairs later,
   // and either emit the 16-pair word or resume hunting after the rejected marker.
   task automatic runStream(input string tag);
      int n;
      int i;
      logic [31:0] w;
      n = stimPairs.size();
      for (int e = 0; e < n; e++) begin
         expPush[e] = 1'b0;
         expErr[e]  = 1'b0;
         expDrop[e] = 1'b0;
         expWord[e] = 32'd0;
      end
      i = 0;
      while (i < n) begin
         if (stimPairs[i] != 2'b10) begin
            i++;
         end else if (i + 15 >= n) begin
            i = n;
         end else if (stimPairs[i + 8] != 2'b01) begin
            expErr[i + 8] = 1'b1;
            i += 9;
         end else begin
            w = 32'd0;
            for (int k = 0; k < 16; k++) w = w * 32'd4 + 32'(stimPairs[i + k]);
            if (stimFull[i + 15]) expDrop[i + 15] = 1'b1;
            else begin
               expPush[i + 15] = 1'b1;
               expWord[i + 15] = w;
            end
            i += 16;
         end
      end
      for (int e = 0; e < n; e++) begin
         applyStimulus(stimPairs[e], stimFull[e]);
         if (expPush[e]) mLastData = expWord[e];
         if (expDrop[e] && DropEn && mDrop < MaxDrop) mDrop++;
         checkOutput({tag, "_push"}, 32'(fifoPush), 32'(expPush[e]));
         checkOutput({tag, "_syncErr"}, 32'(syncErr), 32'(expErr[e]));
         checkOutput({tag, "_data"}, fifoData, mLastData);
         checkOutput({tag, "_drop"}, 32'(dropCount), mDrop);
      end
      stimPairs.delete();
      stimFull.delete();
   endtask

   initial begin
      logic [31:0] w;
      rstB      = 1'b0;
      ddrData   = 2'b00;
      fifoFull  = 1'b0;
      mLastData = 32'd0;
      mDrop     = 0;

      // Reset values while held in reset
      @(posedge clock);
      @(posedge clock);
      #1;
      checkOutput("rst_push", 32'(fifoPush), 32'd0);
      checkOutput("rst_data", fifoData, 32'd0);
      checkOutput("rst_syncErr", 32'(syncErr), 32'd0);
      checkOutput("rst_drop", 32'(dropCount), 32'd0);
      checkOutput("rst_state", 32'(debugState), 32'd0);
      checkOutput("writeClkHigh", 32'(writeClk), 32'(clock));
      #5;
      checkOutput("writeClkLow", 32'(writeClk), 32'(clock));
      @(posedge clock);
      #1;
      rstB = 1'b1;

      $display("[TB] single word");
      pushWord(32'hA1234567, 1'b0);
      padIdle(20);
      runStream("single");

      $display("[TB] back-to-back words");
      pushWord(32'hA1234567, 1'b0);
      pushWord(32'h80004000, 1'b0);
      pushWord(32'hBFFF7FFF, 1'b0);
      padIdle(20);
      runStream("b2b");

      $display("[TB] bad Q marker");
      pushWord(32'hA123C567, 1'b0);
      padIdle(16);
      pushWord(32'h80004000, 1'b0);
      padIdle(20);
      runStream("badQ");

      $display("[TB] fifo full");
      pushWord(32'hA1234567, 1'b1);
      pushWord(32'h80004000, 1'b0);
      padIdle(20);
      runStream("full");

      $display("[TB] reset mid-word");
      w = 32'h80004000;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(2'((w >> (30 - 2 * k)) & 32'd3), 1'b0);
         checkOutput("preRst_push", 32'(fifoPush), 32'd0);
      end
      rstB = 1'b0;
      #1;
      checkOutput("midRst_push", 32'(fifoPush), 32'd0);
      checkOutput("midRst_data", fifoData, 32'd0);
      checkOutput("midRst_syncErr", 32'(syncErr), 32'd0);
      checkOutput("midRst_drop", 32'(dropCount), 32'd0);
      checkOutput("midRst_state", 32'(debugState), 32'd0);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(2'b10, 1'b0);
         checkOutput("heldRst_state", 32'(debugState), 32'd0);
         checkOutput("heldRst_push", 32'(fifoPush), 32'd0);
      end
      rstB      = 1'b1;
      mLastData = 32'd0;
      mDrop     = 0;
      pushWord(32'h80004000, 1'b0);
      padIdle(20);
      runStream("postRst");

      $display("[TB] idle line");
      for (int k = 0; k < 100; k++) begin
         applyStimulus(2'b00, 1'b0);
         checkOutput("idle_state", 32'(debugState), 32'd0);
         checkOutput("idle_push", 32'(fifoPush), 32'd0);
      end

      // Random words with noise gaps, occasional corrupted Q markers and random full flag
      $display("[TB] random stream");
      for (int k = 0; k < 14; k++) begin
         for (int g = $urandom_range(0, 3); g > 0; g--) begin
            stimPairs.push_back(2'($urandom_range(0, 3)));
            stimFull.push_back($urandom_range(0, 3) == 0);
         end
         w = {2'b10, 14'($urandom), 2'b01, 14'($urandom)};
         if ($urandom_range(0, 4) == 0) w[15:14] = 2'($urandom_range(2, 4) & 3);
         for (int p = 0; p < 16; p++) begin
            stimPairs.push_back(2'((w >> (30 - 2 * p)) & 32'd3));
            stimFull.push_back($urandom_range(0, 3) == 0);
         end
      end
      padIdle(20);
      runStream("rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
